// File: rtl/video_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_mem_pkg
// Purpose : Definitions shared by the frame-buffer reader and writer.
//           - AXI burst-type encodings
//           - read-size helper function
//           - reader FSM state type
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package video_mem_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } rd_state_e;

  // Converts a beat width in bits into the AXI size code log2(bytes per beat).
  function automatic logic [2:0] size_from_width(input int unsigned width);
    int unsigned bytes;
    logic [2:0]  sz;
    bytes = width / 8;
    sz    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) sz = i[2:0];
    end
    return sz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_reader_if.sv
`default_nettype none
// ============================================================================
// Module  : memory_reader_if
// Purpose : Bus bundle of the frame reader: read-control channel towards the
//           AXI burst master plus the AXI-stream video output.
// Ports   : read channel  start_read, read_addr, read_len, read_size,
//                         read_burst, read_data, read_valid, read_last,
//                         read_ready
//           video stream  m_axis_tdata, m_axis_tvalid, m_axis_tready,
//                         m_axis_tlast, m_axis_tuser
//           modport master = reader side, modport slave = environment side
// Rev     : 1.0  initial release
// ============================================================================
interface memory_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  start_read;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [31:0]           read_len;
  logic [2:0]            read_size;
  logic [1:0]            read_burst;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  read_last;
  logic                  read_ready;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  modport master (
    output start_read, read_addr, read_len, read_size, read_burst, read_ready,
    input  read_data, read_valid, read_last,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport slave (
    input  start_read, read_addr, read_len, read_size, read_burst, read_ready,
    output read_data, read_valid, read_last,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock first-word-fall-through FIFO. The head entry is
//           presented on dout whenever empty is low; a push while full is
//           accepted only together with a pop.
// Ports   : clk, rst_n (async, active-low)
//           push, din      write side
//           pop, dout      read side
//           full, empty    status
//           free_cnt       number of free entries
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int               c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_DEPTH = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic [c_AW:0]    w_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign empty     = (w_count == '0);
  assign full      = (w_count == c_DEPTH);
  assign free_cnt  = c_DEPTH - w_count;
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/memory_reader.sv
`default_nettype none
// ============================================================================
// Module  : memory_reader
// Purpose : Fetches a stored video frame with INCR read bursts, buffers the
//           returned beats in a FIFO and replays them as an AXI-stream
//           (tuser on the first pixel, tlast at each end of line).
// Ports   : clk, rst_n (async, active-low)
//           frame_ready, base_addr_in, pixels_per_frame, frame_width  frame
//           busy, frame_done                                          status
//           bus (memory_reader_if.master)  read channel + video stream
//           frames_dropped, frames_read   only with MEMORY_READER_STATS_EN
// Macro   : MEMORY_READER_STATS_EN adds the frame statistics outputs.
// Rev     : 1.0  initial release
// ============================================================================
module memory_reader
  import video_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [31:0]           pixels_per_frame,
  input  logic [15:0]           frame_width,
  output logic                  busy,
  output logic                  frame_done,
`ifdef MEMORY_READER_STATS_EN
  output logic [15:0]           frames_dropped,
  output logic [15:0]           frames_read,
`endif
  memory_reader_if.master       bus
);

  localparam int          c_FAW   = $clog2(FIFO_DEPTH);
  localparam logic [31:0] c_BURST = 32'(BURST_LEN);
  localparam logic [31:0] c_BYTES = 32'(DATA_WIDTH / 8);
  localparam logic [2:0]  c_SIZE  = size_from_width(DATA_WIDTH);

  rd_state_e             r_state;
  rd_state_e             w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr_cnt;
  logic [31:0]           r_remaining;
  logic [31:0]           r_pixels;
  logic [15:0]           r_width;
  logic [31:0]           r_beat_cnt;
  logic [31:0]           r_pix_cnt;
  logic [15:0]           r_col_cnt;
  logic                  r_busy;
  logic                  r_rdy_en;

  logic [31:0]           w_beats;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_beat;
  logic                  w_full;
  logic                  w_empty;
  logic [c_FAW:0]        w_free;
  logic [DATA_WIDTH-1:0] w_dout;

  // ---------------------------------------------------------------------------
  // Burst sizing and handshakes
  // ---------------------------------------------------------------------------
  assign w_beats     = (r_remaining < c_BURST) ? r_remaining : c_BURST;
  // A burst is only requested once the FIFO can absorb all of it, so the
  // slave never sees read_ready drop in the middle of a burst.
  assign w_issue     = (r_state == ST_ISSUE) && (32'(w_free) >= w_beats);
  assign w_push      = bus.read_valid & bus.read_ready & (r_state == ST_WAIT_DATA);
  assign w_last_beat = (r_beat_cnt == w_beats - 32'd1);
  assign w_pop       = bus.m_axis_tvalid & bus.m_axis_tready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (frame_ready)
          w_next_state = (pixels_per_frame == 32'd0) ? ST_DRAIN : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_issue) w_next_state = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        // The beat count ends the burst; read_last is only cross-checked.
        if (w_push && w_last_beat)
          w_next_state = ((r_remaining - w_beats) != 32'd0) ? ST_ISSUE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_pix_cnt == r_pixels) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_cnt  <= '0;
      r_remaining <= '0;
      r_pixels    <= '0;
      r_width     <= '0;
      r_beat_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_col_cnt   <= '0;
      r_busy      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && frame_ready) begin
        r_addr_cnt  <= base_addr_in;
        r_remaining <= pixels_per_frame;
        r_pixels    <= pixels_per_frame;
        r_width     <= frame_width;
        r_busy      <= 1'b1;
      end

      if (w_push) begin
        if (w_last_beat) begin
          r_beat_cnt  <= '0;
          r_addr_cnt  <= r_addr_cnt + ADDR_WIDTH'(w_beats * c_BYTES);
          r_remaining <= r_remaining - w_beats;
        end else begin
          r_beat_cnt  <= r_beat_cnt + 32'd1;
        end
      end

      if (r_state == ST_DONE) begin
        r_pix_cnt <= '0;
        r_col_cnt <= '0;
        r_busy    <= 1'b0;
      end else if (w_pop) begin
        r_pix_cnt <= r_pix_cnt + 32'd1;
        r_col_cnt <= (r_col_cnt == r_width - 16'd1) ? 16'd0 : r_col_cnt + 16'd1;
      end
    end
  end

  // Keeps read_ready low while in reset and for the first cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read-data FIFO
  // ---------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .din      (bus.read_data),
    .pop      (w_pop),
    .dout     (w_dout),
    .full     (w_full),
    .empty    (w_empty),
    .free_cnt (w_free)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.start_read    = w_issue;
  assign bus.read_addr     = w_issue ? r_addr_cnt : '0;
  assign bus.read_len      = w_issue ? (w_beats - 32'd1) : '0;
  assign bus.read_size     = c_SIZE;
  assign bus.read_burst    = AXI_BURST_INCR;
  assign bus.read_ready    = r_rdy_en & ~w_full;

  // Stream outputs are forced to zero while the FIFO is empty so that they
  // read as zero during reset.
  assign bus.m_axis_tvalid = ~w_empty;
  assign bus.m_axis_tdata  = w_empty ? '0 : w_dout;
  assign bus.m_axis_tlast  = ~w_empty & (r_col_cnt == r_width - 16'd1);
  assign bus.m_axis_tuser  = ~w_empty & (r_pix_cnt == 32'd0);

  assign busy       = r_busy;
  assign frame_done = (r_state == ST_DONE);

`ifdef MEMORY_READER_STATS_EN
  logic [15:0] r_frames_dropped;
  logic [15:0] r_frames_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frames_dropped <= '0;
      r_frames_read    <= '0;
    end else begin
      if (frame_ready && r_busy && (r_frames_dropped != 16'hFFFF))
        r_frames_dropped <= r_frames_dropped + 16'd1;
      if (r_state == ST_DONE)
        r_frames_read <= r_frames_read + 16'd1;
    end
  end

  assign frames_dropped = r_frames_dropped;
  assign frames_read    = r_frames_read;
`endif

  // read_last from the slave must coincide with the beat the count ends on.
  property p_last_on_final_beat;
    @(posedge clk) disable iff (!rst_n) w_push |-> (bus.read_last == w_last_beat);
  endproperty
  a_last_on_final_beat: assert property (p_last_on_final_beat);

endmodule
`default_nettype wire
